// File: rtl/id_exe_hazard_reg.sv
// ID/EXE pipeline register with load-use / RAW hazard detection,
// branch flush, global freeze and a saturating hazard-bubble counter.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   freeze              hold all state (memory interface busy)
//   flush               branch taken in EXE, load a bubble
//   forwarding_enable   1: stall on load-use only, 0: stall on any RAW
//   id_*                decoded instruction fields from ID
//   mem_dest, mem_wb_en destination / write enable of the MEM instruction
//   exe_*               registered fields presented to EXE
//   hazard_stall        combinational hold request for PC and IF/ID
//   stall_count         saturating count of hazard bubbles
module id_exe_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              forwarding_enable,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_src1,
    input  logic [4:0]        id_src2,
    input  logic [4:0]        id_src3,
    input  logic [4:0]        id_dest,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_store_bne,
    input  logic              id_valid,
    input  logic [3:0]        id_exe_cmd,
    input  logic [4:0]        mem_dest,
    input  logic              mem_wb_en,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_imm,
    output logic [4:0]        exe_src1,
    output logic [4:0]        exe_src2,
    output logic [4:0]        exe_src3,
    output logic [4:0]        exe_dest,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_store_bne,
    output logic              exe_valid,
    output logic [3:0]        exe_exe_cmd,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_count
);

    logic m1e, m2e, m1m, m2m;
    logic bubble;

    // Register 0 is not exempted so this matches the forwarding comparators.
    always_comb begin
        m1e = (id_src1 == exe_dest) & exe_wb_en;
        m2e = id_two_src & (id_src2 == exe_dest) & exe_wb_en;
        m1m = (id_src1 == mem_dest) & mem_wb_en;
        m2m = id_two_src & (id_src2 == mem_dest) & mem_wb_en;
        hazard_stall = 1'b0;
        if (id_valid) begin
            if (forwarding_enable)
                hazard_stall = exe_mem_r_en & (m1e | m2e);
            else
                hazard_stall = m1e | m2e | m1m | m2m;
        end
    end

    assign bubble = flush | hazard_stall;

    // Data fields follow ID even on a bubble; a bubble has no side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_pc   <= '0;
            exe_val1 <= '0;
            exe_val2 <= '0;
            exe_imm  <= '0;
        end else if (!freeze) begin
            exe_pc   <= id_pc;
            exe_val1 <= id_val1;
            exe_val2 <= id_val2;
            exe_imm  <= id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_src1      <= '0;
            exe_src2      <= '0;
            exe_src3      <= '0;
            exe_dest      <= '0;
            exe_wb_en     <= 1'b0;
            exe_mem_r_en  <= 1'b0;
            exe_mem_w_en  <= 1'b0;
            exe_store_bne <= 1'b0;
            exe_valid     <= 1'b0;
            exe_exe_cmd   <= '0;
        end else if (!freeze) begin
            if (bubble) begin
                exe_src1      <= '0;
                exe_src2      <= '0;
                exe_src3      <= '0;
                exe_dest      <= '0;
                exe_wb_en     <= 1'b0;
                exe_mem_r_en  <= 1'b0;
                exe_mem_w_en  <= 1'b0;
                exe_store_bne <= 1'b0;
                exe_valid     <= 1'b0;
                exe_exe_cmd   <= '0;
            end else begin
                exe_src1      <= id_src1;
                exe_src2      <= id_src2;
                exe_src3      <= id_src3;
                exe_dest      <= id_dest;
                exe_wb_en     <= id_wb_en;
                exe_mem_r_en  <= id_mem_r_en;
                exe_mem_w_en  <= id_mem_w_en;
                exe_store_bne <= id_store_bne;
                exe_valid     <= id_valid;
                exe_exe_cmd   <= id_exe_cmd;
            end
        end
    end

    // Flush takes priority, so a flushed hazard is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (!freeze && !flush && hazard_stall &&
                 stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// Directed self-checking bench for id_exe_hazard_reg.
// Counter width is 2 so saturation is reachable in a few cycles.
module tb_id_exe_hazard_reg;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          freeze, flush, forwarding_enable;
    logic [DW-1:0] id_pc, id_val1, id_val2, id_imm;
    logic [4:0]    id_src1, id_src2, id_src3, id_dest;
    logic          id_two_src, id_wb_en, id_mem_r_en, id_mem_w_en;
    logic          id_store_bne, id_valid;
    logic [3:0]    id_exe_cmd;
    logic [4:0]    mem_dest;
    logic          mem_wb_en;
    logic [DW-1:0] exe_pc, exe_val1, exe_val2, exe_imm;
    logic [4:0]    exe_src1, exe_src2, exe_src3, exe_dest;
    logic          exe_wb_en, exe_mem_r_en, exe_mem_w_en;
    logic          exe_store_bne, exe_valid;
    logic [3:0]    exe_exe_cmd;
    logic          hazard_stall;
    logic [CW-1:0] stall_count;

    int total = 0;
    int bad = 0;

    id_exe_hazard_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .forwarding_enable(forwarding_enable),
        .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2),
        .id_imm(id_imm), .id_src1(id_src1), .id_src2(id_src2),
        .id_src3(id_src3), .id_dest(id_dest), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_store_bne(id_store_bne),
        .id_valid(id_valid), .id_exe_cmd(id_exe_cmd),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .exe_pc(exe_pc), .exe_val1(exe_val1), .exe_val2(exe_val2),
        .exe_imm(exe_imm), .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_src3(exe_src3), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_mem_w_en(exe_mem_w_en), .exe_store_bne(exe_store_bne),
        .exe_valid(exe_valid), .exe_exe_cmd(exe_exe_cmd),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s1,
                          input logic [4:0] s2, input logic two,
                          input logic [4:0] d, input logic wb,
                          input logic mr);
        id_valid     = v;
        id_src1      = s1;
        id_src2      = s2;
        id_src3      = 5'd0;
        id_two_src   = two;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_r_en  = mr;
        id_mem_w_en  = 1'b0;
        id_store_bne = 1'b0;
        id_exe_cmd   = v ? 4'h3 : 4'h0;
        id_pc        = 32'h100 + {27'd0, d};
        id_val1      = 32'hA0;
        id_val2      = 32'hB0;
        id_imm       = 32'hC0;
        #1;
    endtask

    task automatic set_mem(input logic [4:0] d, input logic wb);
        mem_dest  = d;
        mem_wb_en = wb;
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        set_mem(5'd0, 1'b0);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        freeze = 1'b0;
        flush = 1'b0;
        forwarding_enable = 1'b1;
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);

        // reset held across edges with live ID inputs
        repeat (3) tick;
        chk("rst_valid", exe_valid, 0);
        chk("rst_pc", exe_pc, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_dest", exe_dest, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_hs", hazard_stall, 0);
        tick;
        chk("load_valid", exe_valid, 1);
        chk("load_pc", exe_pc, 32'h107);
        chk("load_cmd", exe_exe_cmd, 4'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", exe_valid, 0);
        chk("async_pc", exe_pc, 0);

        // load-use with forwarding enabled
        do_reset;
        forwarding_enable = 1'b1;
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        chk("lu_ldr_hs", hazard_stall, 0);
        tick;
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        chk("lu_hs1", hazard_stall, 1);
        tick;
        chk("lu_bub_valid", exe_valid, 0);
        chk("lu_bub_dest", exe_dest, 0);
        chk("lu_bub_src1", exe_src1, 0);
        chk("lu_cnt1", stall_count, 1);
        set_mem(5'd3, 1'b1);
        chk("lu_hs2", hazard_stall, 0);
        tick;
        chk("lu_add_valid", exe_valid, 1);
        chk("lu_add_src1", exe_src1, 3);
        chk("lu_add_src2", exe_src2, 5);
        chk("lu_add_dest", exe_dest, 4);
        chk("lu_cnt_end", stall_count, 1);

        // forwarding disabled, producer adjacent: two bubbles
        do_reset;
        forwarding_enable = 1'b0;
        set_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick;
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("nf_hs_e", hazard_stall, 1);
        tick;
        chk("nf_bub1", exe_valid, 0);
        set_mem(5'd2, 1'b1);
        chk("nf_hs_m", hazard_stall, 1);
        tick;
        chk("nf_bub2", exe_valid, 0);
        chk("nf_cnt2", stall_count, 2);
        set_mem(5'd0, 1'b0);
        chk("nf_hs_clr", hazard_stall, 0);
        tick;
        chk("nf_sub_dest", exe_dest, 6);
        chk("nf_sub_valid", exe_valid, 1);

        // forwarding disabled, one independent instruction between
        do_reset;
        set_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick;
        set_id(1'b1, 5'd10, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        chk("gap_or_hs", hazard_stall, 0);
        tick;
        set_mem(5'd2, 1'b1);
        set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("gap_hs", hazard_stall, 1);
        tick;
        chk("gap_bub", exe_valid, 0);
        set_mem(5'd9, 1'b1);
        chk("gap_hs_clr", hazard_stall, 0);
        tick;
        chk("gap_sub_dest", exe_dest, 6);
        chk("gap_cnt", stall_count, 1);

        // gating by two_src and id_valid
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd6, 1'b0, 5'd8, 1'b0, 1'b0);
        chk("two_src_gate", hazard_stall, 0);
        set_id(1'b1, 5'd1, 5'd6, 1'b1, 5'd8, 1'b0, 1'b0);
        chk("two_src_hit", hazard_stall, 1);
        set_id(1'b0, 5'd6, 5'd6, 1'b1, 5'd8, 1'b0, 1'b0);
        chk("valid_gate", hazard_stall, 0);

        // flush alone, then flush with a load-use hazard
        do_reset;
        forwarding_enable = 1'b1;
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        flush = 1'b1;
        tick;
        chk("fl_bub", exe_valid, 0);
        chk("fl_cnt", stall_count, 0);
        flush = 1'b0;
        tick;
        chk("fl_after_dest", exe_dest, 5);
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick;
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_hs_seen", hazard_stall, 1);
        tick;
        chk("fl_hz_bub", exe_valid, 0);
        chk("fl_hz_cnt", stall_count, 0);
        flush = 1'b0;

        // freeze during a load-use hazard
        do_reset;
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick;
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fz_dest", exe_dest, 3);
            chk("fz_mr", exe_mem_r_en, 1);
            chk("fz_cnt", stall_count, 0);
            chk("fz_hs", hazard_stall, 1);
        end
        freeze = 1'b0;
        tick;
        chk("fz_rel_bub", exe_valid, 0);
        chk("fz_rel_cnt", stall_count, 1);
        set_mem(5'd3, 1'b1);
        tick;
        chk("fz_add_src1", exe_src1, 3);

        // saturation of the 2-bit counter
        do_reset;
        forwarding_enable = 1'b0;
        set_mem(5'd2, 1'b1);
        set_id(1'b1, 5'd2, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        chk("sat_hs", hazard_stall, 1);
        tick;
        chk("sat_c1", stall_count, 1);
        tick;
        chk("sat_c2", stall_count, 2);
        tick;
        chk("sat_c3", stall_count, 3);
        tick;
        chk("sat_c4", stall_count, 3);
        tick;
        chk("sat_c5", stall_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_hazard_reg.md
# id_exe_hazard_reg

ID/EXE pipeline register with integrated hazard detection for the 5-stage pipeline. It captures decoded instruction fields from ID and presents them to EXE, including the registered `src1/src2/src3` numbers that drive the forwarding unit. It detects data hazards that forwarding cannot resolve, inserts bubbles, and stalls IF/ID. It also handles branch flush and global memory freeze, and keeps a saturating count of hazard bubbles.

## Interface
Parameters:
- `DATA_W`, 32, width of PC, operand and immediate fields
- `CNT_W`, 16, width of the hazard-bubble counter

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `freeze`  in  1  global hold from memory interface; register holds all contents
- `flush`  in  1  branch taken in EXE; next load is a bubble
- `forwarding_enable`  in  1  forwarding active; selects the stall policy
- `id_pc, id_val1, id_val2, id_imm`  in  DATA_W each  decoded ID data
- `id_src1, id_src2, id_src3, id_dest`  in  5 each  ID register numbers
- `id_two_src`  in  1  instruction reads `id_src2`
- `id_wb_en, id_mem_r_en, id_mem_w_en, id_store_bne, id_valid`  in  1 each  ID control
- `id_exe_cmd`  in  4  ALU command
- `mem_dest`  in  5  destination of the instruction in MEM
- `mem_wb_en`  in  1  write enable of the instruction in MEM
- `exe_pc, exe_val1, exe_val2, exe_imm`  out  DATA_W each  registered data
- `exe_src1, exe_src2, exe_src3, exe_dest`  out  5 each  registered register numbers
- `exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_store_bne, exe_valid`  out  1 each  registered control
- `exe_exe_cmd`  out  4  registered ALU command
- `hazard_stall`  out  1  combinational; holds PC and IF/ID
- `stall_count`  out  CNT_W  saturating count of hazard bubbles

## Operation
Match terms:
- `m1e = (id_src1==exe_dest) & exe_wb_en`
- `m2e = id_two_src & (id_src2==exe_dest) & exe_wb_en`
- `m1m`, `m2m`: the same terms, computed against `mem_dest` / `mem_wb_en`
- No register-0 exemption, consistent with the forwarding comparators.

`hazard_stall` equation, all terms gated by `id_valid`:
- `forwarding_enable=0`: `m1e|m2e|m1m|m2m`
- `forwarding_enable=1`: `exe_mem_r_en & (m1e|m2e)`. This is load-use only.

Register update priority on each clock edge:
1. `freeze=1`: hold every register and `stall_count`.
2. `flush=1`: load a bubble.
3. `hazard_stall=1`: load a bubble and increment `stall_count`.
4. Otherwise: load all `id_*` fields.

Bubble contents:
- `exe_valid`, `exe_wb_en`, `exe_mem_r_en`, `exe_mem_w_en`, `exe_store_bne` = 0; `exe_exe_cmd` = 0.
- `exe_src1`, `exe_src2`, `exe_src3`, `exe_dest` = 0.
- Data fields may take any value, because a bubble has no side effects.

Stall and counter behaviour:
- `hazard_stall` is asserted even during `freeze` or `flush`; upstream gates it by the same priority.
- `stall_count` saturates at all-ones and does not wrap.
- Counting happens only under rule 3, never during freeze or flush.

## Timing
- Reset: all `exe_*` outputs = 0 and `stall_count` = 0, applied immediately on `rst_n` low regardless of `clk`. Reset mid-stall drops the bubble state; the first edge after release follows the normal rules.
- Latency: 1 cycle from ID fields to `exe_*`.
- `hazard_stall` is combinational from the current-cycle ID inputs, `mem_*` and the registered `exe_*` fields.
- Load-use with forwarding enabled: exactly 1 bubble, then the dependent instruction enters EXE with the load in MEM, where the forwarding unit sources it.
- Forwarding disabled, producer in EXE: 2 bubbles (EXE match, then MEM match).
- Forwarding disabled, producer in MEM: 1 bubble.
- WB-stage writes never stall, because the register file writes in the first half-cycle.
- Simultaneous `flush` and `hazard_stall`: a bubble is loaded and `stall_count` is not incremented.

## Test plan
- Reset: hold `rst_n`=0, toggle `clk`, release → all outputs 0 and `stall_count`=0. Assert `rst_n`=0 mid-cycle → outputs clear before the next edge.
- Load-use with forwarding enabled: LDR r3 followed by ADD r4,r3,r5 → `hazard_stall`=1 for 1 cycle, 1 bubble (`exe_valid`=0), `stall_count`=1, then ADD appears with `exe_src1`=3.
- Forwarding disabled: ADD r2 followed by SUB r6,r2,r2 → 2 bubble cycles, `stall_count`=2. With one independent instruction between them → 1 bubble.
- Flush, alone and with a hazard: `flush`=1 alone → bubble with `stall_count` unchanged. `flush` together with a load-use hazard → bubble with `stall_count` unchanged.
- Freeze during a hazard: `freeze`=1 for 3 cycles while a load-use hazard is present → `exe_*` held and counter unchanged. On release → 1 bubble and counter +1.
- Saturation: preload the count by forcing 2^CNT_W−1 hazards (or use CNT_W=2 with 5 hazards) → `stall_count` stays at 3.
